// File: rtl/dca_matrix_row_buffer.sv
// Ping-pong row buffer between the LSU load stream and a row consumer.
// Two banks alternate: one fills from the load side while the other drains to the consumer.
module dca_matrix_row_buffer #(
    parameter int BW_ROW  = 128,
    parameter int NUM_ROW = 4
) (
    input  logic              clk,
    input  logic              rstnn,
    input  logic              clear,
    input  logic              enable,
    input  logic              load_row_wvalid,
    input  logic              load_row_wlast,
    input  logic [BW_ROW-1:0] load_row_wdata,
    output logic              load_row_wready,
    output logic              store_row_rvalid,
    output logic              store_row_rlast,
    output logic [BW_ROW-1:0] store_row_rdata,
    input  logic              store_row_rready,
    output logic [1:0]        num_full_bank,
    output logic              err_nolast,
    output logic              busy
);

    localparam int RW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
    localparam int CW = $clog2(NUM_ROW + 1);

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2
    } bank_state_e;

    bank_state_e       bank_q   [2];
    bank_state_e       bank_d   [2];
    logic [CW-1:0]     rowcnt_q [2];
    logic [CW-1:0]     rowcnt_d [2];
    logic              wbank_q, wbank_d;
    logic              rbank_q, rbank_d;
    logic [RW-1:0]     wcnt_q, wcnt_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic              err_q, err_d;
    logic [BW_ROW-1:0] mem_q [2][NUM_ROW];

    logic          wr_acc;
    logic          rd_acc;
    logic          wr_close;
    logic          wr_full_close;
    logic [CW-1:0] wcnt_inc;
    logic [CW-1:0] rcnt_inc;

    assign wcnt_inc      = CW'(wcnt_q) + CW'(1);
    assign rcnt_inc      = CW'(rcnt_q) + CW'(1);
    assign wr_full_close = (wcnt_inc == CW'(NUM_ROW));
    assign wr_close      = load_row_wlast | wr_full_close;

    // wready is forced low while rstnn is asserted even though the bank state already reads EMPTY.
    assign load_row_wready  = rstnn & enable & ~clear & (bank_q[wbank_q] != BANK_FULL);
    assign store_row_rvalid = rstnn & enable & (bank_q[rbank_q] == BANK_FULL);
    assign store_row_rlast  = store_row_rvalid & (rcnt_inc == rowcnt_q[rbank_q]);
    assign store_row_rdata  = mem_q[rbank_q][rcnt_q];

    assign wr_acc = load_row_wvalid & load_row_wready;
    assign rd_acc = store_row_rvalid & store_row_rready;

    assign num_full_bank = {1'b0, bank_q[0] == BANK_FULL} + {1'b0, bank_q[1] == BANK_FULL};
    assign busy          = (bank_q[0] != BANK_EMPTY) | (bank_q[1] != BANK_EMPTY);
    assign err_nolast    = err_q;

    always_comb begin
        bank_d[0]   = bank_q[0];
        bank_d[1]   = bank_q[1];
        rowcnt_d[0] = rowcnt_q[0];
        rowcnt_d[1] = rowcnt_q[1];
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        err_d       = err_q;

        // Flush acts independently of enable and overrides any accept in the same cycle.
        if (clear) begin
            bank_d[0]   = BANK_EMPTY;
            bank_d[1]   = BANK_EMPTY;
            rowcnt_d[0] = '0;
            rowcnt_d[1] = '0;
            wbank_d     = 1'b0;
            rbank_d     = 1'b0;
            wcnt_d      = '0;
            rcnt_d      = '0;
            err_d       = 1'b0;
        end else begin
            if (wr_acc) begin
                if (wr_close) begin
                    bank_d[wbank_q]   = BANK_FULL;
                    rowcnt_d[wbank_q] = wcnt_inc;
                    wcnt_d            = '0;
                    wbank_d           = ~wbank_q;
                    if (wr_full_close && !load_row_wlast) begin
                        err_d = 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt_q + RW'(1);
                    if (bank_q[wbank_q] == BANK_EMPTY) begin
                        bank_d[wbank_q] = BANK_FILL;
                    end
                end
            end
            // A writable bank is never FULL and a readable one always is, so these never collide.
            if (rd_acc) begin
                if (store_row_rlast) begin
                    rcnt_d          = '0;
                    bank_d[rbank_q] = BANK_EMPTY;
                    rbank_d         = ~rbank_q;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            bank_q[0]   <= BANK_EMPTY;
            bank_q[1]   <= BANK_EMPTY;
            rowcnt_q[0] <= '0;
            rowcnt_q[1] <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            bank_q[0]   <= bank_d[0];
            bank_q[1]   <= bank_d[1];
            rowcnt_q[0] <= rowcnt_d[0];
            rowcnt_q[1] <= rowcnt_d[1];
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            err_q       <= err_d;
        end
    end

    // Row storage carries no reset; only the bank state qualifies its contents.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wbank_q][wcnt_q] <= load_row_wdata;
        end
    end

endmodule

// File: tb/tb_dca_matrix_row_buffer.sv
// Directed bench for dca_matrix_row_buffer with NUM_ROW=4 and BW_ROW=128.
module tb_dca_matrix_row_buffer;

    logic         clk;
    logic         rstnn;
    logic         clear;
    logic         enable;
    logic         wvalid;
    logic         wlast;
    logic [127:0] wdata;
    logic         wready;
    logic         rvalid;
    logic         rlast;
    logic [127:0] rdata;
    logic         rready;
    logic [1:0]   nfb;
    logic         err;
    logic         busy;

    int total;
    int bad;

    dca_matrix_row_buffer #(.BW_ROW(128), .NUM_ROW(4)) dut (
        .clk              (clk),
        .rstnn            (rstnn),
        .clear            (clear),
        .enable           (enable),
        .load_row_wvalid  (wvalid),
        .load_row_wlast   (wlast),
        .load_row_wdata   (wdata),
        .load_row_wready  (wready),
        .store_row_rvalid (rvalid),
        .store_row_rlast  (rlast),
        .store_row_rdata  (rdata),
        .store_row_rready (rready),
        .num_full_bank    (nfb),
        .err_nolast       (err),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] row(input logic [7:0] tag, input int k);
        return {tag, 24'hC0FFEE, 64'h0, 32'(k)};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstnn = 1'b0; clear = 1'b0; enable = 1'b1;
        wvalid = 1'b0; wlast = 1'b0; wdata = '0; rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (wready !== 1'b0) begin bad++; $display("FAIL reset_wready got=%0b exp=0", wready); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0b exp=0", rvalid); end
        total++; if (rlast !== 1'b0) begin bad++; $display("FAIL reset_rlast got=%0b exp=0", rlast); end
        total++; if (nfb !== 2'd0) begin bad++; $display("FAIL reset_nfb got=%0d exp=0", nfb); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
        rstnn = 1'b1;
        #1;
        total++; if (wready !== 1'b1) begin bad++; $display("FAIL reset_release_wready got=%0b exp=1", wready); end
        next_cycle();
    endtask

    task automatic test_basic();
        rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wvalid = 1'b1; wdata = row(8'hA0, k); wlast = (k == 3);
            #1;
            total++; if (wready !== 1'b1) begin bad++; $display("FAIL basic_wready[%0d] got=%0b exp=1", k, wready); end
            total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL basic_early_rvalid[%0d] got=%0b exp=0", k, rvalid); end
            next_cycle();
        end
        wvalid = 1'b0; wlast = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL basic_rvalid[%0d] got=%0b exp=1", k, rvalid); end
            total++; if (rdata !== row(8'hA0, k)) begin bad++; $display("FAIL basic_rdata[%0d] got=%0h exp=%0h", k, rdata, row(8'hA0, k)); end
            total++; if (rlast !== (k == 3)) begin bad++; $display("FAIL basic_rlast[%0d] got=%0b exp=%0b", k, rlast, k == 3); end
            total++; if (nfb !== 2'd1) begin bad++; $display("FAIL basic_nfb[%0d] got=%0d exp=1", k, nfb); end
            next_cycle();
        end
        #1;
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL basic_done_rvalid got=%0b exp=0", rvalid); end
        total++; if (nfb !== 2'd0) begin bad++; $display("FAIL basic_done_nfb got=%0d exp=0", nfb); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_done_busy got=%0b exp=0", busy); end
        rready = 1'b0;
        next_cycle();
    endtask

    task automatic test_short();
        rready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wvalid = 1'b1; wdata = row(8'hB0, k); wlast = (k == 1);
            next_cycle();
        end
        wvalid = 1'b0; wlast = 1'b0;
        #1;
        total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL short_rvalid got=%0b exp=1", rvalid); end
        total++; if (nfb !== 2'd1) begin bad++; $display("FAIL short_nfb got=%0d exp=1", nfb); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL short_err got=%0b exp=0", err); end
        total++; if (rlast !== 1'b0) begin bad++; $display("FAIL short_hold_rlast got=%0b exp=0", rlast); end
        next_cycle();
        rready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (rdata !== row(8'hB0, k)) begin bad++; $display("FAIL short_rdata[%0d] got=%0h exp=%0h", k, rdata, row(8'hB0, k)); end
            total++; if (rlast !== (k == 1)) begin bad++; $display("FAIL short_rlast[%0d] got=%0b exp=%0b", k, rlast, k == 1); end
            next_cycle();
        end
        rready = 1'b0;
        #1;
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL short_done_rvalid got=%0b exp=0", rvalid); end
        next_cycle();
    endtask

    task automatic test_nolast();
        rready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wvalid = 1'b1; wdata = row(8'hC0, k); wlast = 1'b0;
            #1;
            total++; if (err !== 1'b0) begin bad++; $display("FAIL nolast_err_pre[%0d] got=%0b exp=0", k, err); end
            next_cycle();
        end
        wvalid = 1'b0;
        #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL nolast_err got=%0b exp=1", err); end
        total++; if (nfb !== 2'd1) begin bad++; $display("FAIL nolast_nfb got=%0d exp=1", nfb); end
        total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL nolast_rvalid got=%0b exp=1", rvalid); end
        next_cycle();
        rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (rdata !== row(8'hC0, k)) begin bad++; $display("FAIL nolast_rdata[%0d] got=%0h exp=%0h", k, rdata, row(8'hC0, k)); end
            total++; if (rlast !== (k == 3)) begin bad++; $display("FAIL nolast_rlast[%0d] got=%0b exp=%0b", k, rlast, k == 3); end
            next_cycle();
        end
        rready = 1'b0;
        #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL nolast_sticky got=%0b exp=1", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nolast_busy got=%0b exp=0", busy); end
        next_cycle();
        clear = 1'b1;
        #1;
        total++; if (wready !== 1'b0) begin bad++; $display("FAIL nolast_clear_wready got=%0b exp=0", wready); end
        next_cycle();
        clear = 1'b0;
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL nolast_cleared_err got=%0b exp=0", err); end
        total++; if (wready !== 1'b1) begin bad++; $display("FAIL nolast_cleared_wready got=%0b exp=1", wready); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        rready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wvalid = 1'b1;
            wdata  = (k < 2) ? row(8'hD0, k) : row(8'hE0, k - 2);
            wlast  = (k == 1) || (k == 3);
            #1;
            total++; if (wready !== 1'b1) begin bad++; $display("FAIL bp_wready[%0d] got=%0b exp=1", k, wready); end
            next_cycle();
        end
        wvalid = 1'b1; wdata = row(8'hF0, 0); wlast = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (nfb !== 2'd2) begin bad++; $display("FAIL bp_nfb_full[%0d] got=%0d exp=2", k, nfb); end
            total++; if (wready !== 1'b0) begin bad++; $display("FAIL bp_wready_full[%0d] got=%0b exp=0", k, wready); end
            total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL bp_hold_rvalid[%0d] got=%0b exp=1", k, rvalid); end
            total++; if (rdata !== row(8'hD0, 0)) begin bad++; $display("FAIL bp_hold_rdata[%0d] got=%0h exp=%0h", k, rdata, row(8'hD0, 0)); end
            total++; if (rlast !== 1'b0) begin bad++; $display("FAIL bp_hold_rlast[%0d] got=%0b exp=0", k, rlast); end
            next_cycle();
        end
        rready = 1'b1;
        #1;
        total++; if (rdata !== row(8'hD0, 0)) begin bad++; $display("FAIL bp_d0 got=%0h exp=%0h", rdata, row(8'hD0, 0)); end
        next_cycle();
        #1;
        total++; if (wready !== 1'b0) begin bad++; $display("FAIL bp_wready_release got=%0b exp=0", wready); end
        total++; if (rdata !== row(8'hD0, 1)) begin bad++; $display("FAIL bp_d1 got=%0h exp=%0h", rdata, row(8'hD0, 1)); end
        total++; if (rlast !== 1'b1) begin bad++; $display("FAIL bp_d1_rlast got=%0b exp=1", rlast); end
        next_cycle();
        #1;
        total++; if (wready !== 1'b1) begin bad++; $display("FAIL bp_wready_restored got=%0b exp=1", wready); end
        total++; if (nfb !== 2'd1) begin bad++; $display("FAIL bp_nfb_after_release got=%0d exp=1", nfb); end
        total++; if (rdata !== row(8'hE0, 0)) begin bad++; $display("FAIL bp_e0 got=%0h exp=%0h", rdata, row(8'hE0, 0)); end
        next_cycle();
        wdata = row(8'hF0, 1); wlast = 1'b1;
        #1;
        total++; if (rdata !== row(8'hE0, 1)) begin bad++; $display("FAIL bp_e1 got=%0h exp=%0h", rdata, row(8'hE0, 1)); end
        total++; if (rlast !== 1'b1) begin bad++; $display("FAIL bp_e1_rlast got=%0b exp=1", rlast); end
        total++; if (wready !== 1'b1) begin bad++; $display("FAIL bp_f1_wready got=%0b exp=1", wready); end
        next_cycle();
        wvalid = 1'b0; wlast = 1'b0;
        #1;
        total++; if (nfb !== 2'd1) begin bad++; $display("FAIL bp_nfb_swap got=%0d exp=1", nfb); end
        total++; if (rdata !== row(8'hF0, 0)) begin bad++; $display("FAIL bp_f0 got=%0h exp=%0h", rdata, row(8'hF0, 0)); end
        next_cycle();
        #1;
        total++; if (rdata !== row(8'hF0, 1)) begin bad++; $display("FAIL bp_f1 got=%0h exp=%0h", rdata, row(8'hF0, 1)); end
        total++; if (rlast !== 1'b1) begin bad++; $display("FAIL bp_f1_rlast got=%0b exp=1", rlast); end
        next_cycle();
        #1;
        total++; if (nfb !== 2'd0) begin bad++; $display("FAIL bp_nfb_end got=%0d exp=0", nfb); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL bp_rvalid_end got=%0b exp=0", rvalid); end
        rready = 1'b0;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_d;
        int           idx;
        rready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            wvalid = (c < 8);
            wdata  = (c < 4) ? row(8'h60, c) : row(8'h70, c - 4);
            wlast  = (c == 3) || (c == 7);
            #1;
            if (c < 8) begin
                total++; if (wready !== 1'b1) begin bad++; $display("FAIL b2b_wready[%0d] got=%0b exp=1", c, wready); end
            end
            total++; if (rvalid !== (c >= 4)) begin bad++; $display("FAIL b2b_rvalid[%0d] got=%0b exp=%0b", c, rvalid, c >= 4); end
            if (c >= 4) begin
                idx   = c - 4;
                exp_d = (idx < 4) ? row(8'h60, idx) : row(8'h70, idx - 4);
                total++; if (rdata !== exp_d) begin bad++; $display("FAIL b2b_rdata[%0d] got=%0h exp=%0h", c, rdata, exp_d); end
                total++; if (rlast !== ((idx % 4) == 3)) begin bad++; $display("FAIL b2b_rlast[%0d] got=%0b exp=%0b", c, rlast, (idx % 4) == 3); end
            end
            next_cycle();
        end
        wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%0b exp=0", busy); end
        next_cycle();
    endtask

    task automatic test_enable();
        rready = 1'b0;
        wvalid = 1'b1; wdata = row(8'h80, 0); wlast = 1'b0;
        #1;
        total++; if (wready !== 1'b1) begin bad++; $display("FAIL en_k0_wready got=%0b exp=1", wready); end
        next_cycle();
        enable = 1'b0; wdata = row(8'h80, 1); wlast = 1'b1; rready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (wready !== 1'b0) begin bad++; $display("FAIL en_off_wready[%0d] got=%0b exp=0", k, wready); end
            total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL en_off_rvalid[%0d] got=%0b exp=0", k, rvalid); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL en_off_busy[%0d] got=%0b exp=1", k, busy); end
            next_cycle();
        end
        enable = 1'b1;
        #1;
        total++; if (wready !== 1'b1) begin bad++; $display("FAIL en_on_wready got=%0b exp=1", wready); end
        next_cycle();
        wvalid = 1'b0; wlast = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL en_rvalid[%0d] got=%0b exp=1", k, rvalid); end
            total++; if (rdata !== row(8'h80, k)) begin bad++; $display("FAIL en_rdata[%0d] got=%0h exp=%0h", k, rdata, row(8'h80, k)); end
            total++; if (rlast !== (k == 1)) begin bad++; $display("FAIL en_rlast[%0d] got=%0b exp=%0b", k, rlast, k == 1); end
            next_cycle();
        end
        rready = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_busy_end got=%0b exp=0", busy); end
        next_cycle();
    endtask

    task automatic test_clear();
        rready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wvalid = 1'b1; wdata = row(8'h90, k); wlast = 1'b0;
            next_cycle();
        end
        clear = 1'b1; wdata = row(8'h90, 2); wlast = 1'b1;
        #1;
        total++; if (wready !== 1'b0) begin bad++; $display("FAIL clr_fill_wready got=%0b exp=0", wready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_fill_busy_pre got=%0b exp=1", busy); end
        next_cycle();
        clear = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_fill_busy got=%0b exp=0", busy); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL clr_fill_rvalid got=%0b exp=0", rvalid); end
        total++; if (nfb !== 2'd0) begin bad++; $display("FAIL clr_fill_nfb got=%0d exp=0", nfb); end
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            wvalid = 1'b1; wdata = row(8'hB5, k); wlast = (k == 1);
            next_cycle();
        end
        wvalid = 1'b0; wlast = 1'b0; rready = 1'b1;
        #1;
        total++; if (rdata !== row(8'hB5, 0)) begin bad++; $display("FAIL clr_drain_m0 got=%0h exp=%0h", rdata, row(8'hB5, 0)); end
        next_cycle();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0; rready = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_drain_busy got=%0b exp=0", busy); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL clr_drain_rvalid got=%0b exp=0", rvalid); end
        total++; if (nfb !== 2'd0) begin bad++; $display("FAIL clr_drain_nfb got=%0d exp=0", nfb); end
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            wvalid = 1'b1; wdata = row(8'hC5, k); wlast = (k == 1);
            next_cycle();
        end
        wvalid = 1'b0; wlast = 1'b0; rready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL clr_after_rvalid[%0d] got=%0b exp=1", k, rvalid); end
            total++; if (rdata !== row(8'hC5, k)) begin bad++; $display("FAIL clr_after_rdata[%0d] got=%0h exp=%0h", k, rdata, row(8'hC5, k)); end
            total++; if (rlast !== (k == 1)) begin bad++; $display("FAIL clr_after_rlast[%0d] got=%0b exp=%0b", k, rlast, k == 1); end
            next_cycle();
        end
        rready = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_end_busy got=%0b exp=0", busy); end
        next_cycle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_short();
        test_nolast();
        test_backpressure();
        test_back_to_back();
        test_enable();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dca_matrix_row_buffer.md
DCA_MATRIX_ROW_BUFFER -- requirements
Module: dca_matrix_row_buffer

Interface
REQ-001 SHALL have parameter BW_ROW, default 128, bit width of one tensor row.
REQ-002 SHALL have parameter NUM_ROW, default 4, maximum rows per matrix, range 2..16.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rstnn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear  input  1  synchronous flush of all buffer state.
REQ-006 SHALL have port enable  input  1  global advance qualifier.
REQ-007 SHALL have port load_row_wvalid  input  1  load-stream row valid, driven by the LSU load path.
REQ-008 SHALL have port load_row_wlast  input  1  marks the last row of a matrix.
REQ-009 SHALL have port load_row_wdata  input  BW_ROW  row data.
REQ-010 SHALL have port load_row_wready  output  1  buffer accepts a row.
REQ-011 SHALL have port store_row_rvalid  output  1  row available to the consumer.
REQ-012 SHALL have port store_row_rlast  output  1  last row of the current matrix.
REQ-013 SHALL have port store_row_rdata  output  BW_ROW  row data.
REQ-014 SHALL have port store_row_rready  input  1  consumer accepts a row.
REQ-015 SHALL have port num_full_bank  output  2  count of closed, unread banks (0..2).
REQ-016 SHALL have port err_nolast  output  1  sticky flag: a bank closed at NUM_ROW rows without wlast.
REQ-017 SHALL have port busy  output  1  high when any bank is filling, full or draining.

Function
REQ-018 SHALL hold two banks (ping-pong); each bank has NUM_ROW x BW_ROW storage, a row count, and state EMPTY, FILL or FULL.
REQ-019 SHALL keep wbank and rbank pointers, 1 bit each; both reset to 0.
REQ-020 Write accept = wvalid & wready; wready = enable & (bank[wbank] != FULL) & ~clear.
REQ-021 On accept SHALL store wdata at row wcnt of bank[wbank], increment wcnt, and set the bank to FILL if it was EMPTY.
REQ-022 SHALL close the bank on an accept where wlast=1 or wcnt+1 == NUM_ROW: the bank becomes FULL, its row count becomes wcnt+1, wcnt returns to 0, and wbank toggles.
REQ-023 On a close with wcnt+1 == NUM_ROW and wlast=0, SHALL set err_nolast; err_nolast clears only on reset or clear.
REQ-024 store_row_rvalid = enable & (bank[rbank] == FULL); rdata = row rcnt of bank[rbank], combinational from storage, zero added latency.
REQ-025 store_row_rlast = rvalid & (rcnt == rowcount[rbank] - 1).
REQ-026 Read accept = rvalid & rready, which increments rcnt; on an accept with rlast, rcnt returns to 0, the bank becomes EMPTY, and rbank toggles.
REQ-027 Minimum latency from a closing write accept to rvalid SHALL be 1 cycle (FULL is registered).
REQ-028 Simultaneous write into one bank and read from the other SHALL both proceed in the same cycle.
REQ-029 A read-release and a write-close in the same cycle SHALL both take effect; num_full_bank stays unchanged.
REQ-030 With both banks FULL, wready=0 until a release; the freed bank accepts writes from the next cycle.
REQ-031 rdata, rvalid and rlast SHALL stay stable while rvalid=1 and rready=0.
REQ-032 enable=0 SHALL freeze all state; wready=0 and rvalid=0.
REQ-033 clear=1 SHALL, at the next edge, set both banks EMPTY, pointers and counters to 0, and err_nolast to 0; storage contents are don't-care; clear takes precedence over a simultaneous accept.
REQ-034 num_full_bank SHALL equal the number of banks in state FULL.
REQ-035 busy = any bank != EMPTY.

Reset
REQ-036 On rstnn=0, asynchronously: both banks EMPTY, wbank=rbank=0, wcnt=rcnt=0, row counts 0, err_nolast=0.
REQ-037 Outputs during reset: wready=0, rvalid=0, rlast=0, num_full_bank=0, busy=0; storage is not reset.
REQ-038 After rstnn deasserts with enable=1, wready=1 on the first cycle.

Verification
REQ-039 4 rows A0..A3 with wlast on A3, rready=1 -> rvalid rises 1 cycle after the A3 accept; reads A0..A3 with rlast on A3 only; num_full_bank goes 1 then 0.
REQ-040 2 rows with wlast on row 1 -> bank FULL with row count 2; rlast on the second read; err_nolast=0.
REQ-041 4 rows with no wlast (NUM_ROW=4) -> bank closes after the 4th row; err_nolast=1 and stays high until clear.
REQ-042 rready=0, write 3 matrices -> after 2 matrices num_full_bank=2 and wready=0; one full drain restores wready on the next cycle.
REQ-043 Continuous stream with rready=1 -> reads of bank 0 overlap writes to bank 1, one row per cycle each, with no bubble.
REQ-044 clear asserted mid-fill (2 rows written) and mid-drain -> next cycle busy=0, rvalid=0, num_full_bank=0; a following matrix reads back correctly from bank 0.
